dsa_mem_arbiter: RTL
====================

# dsa_mem_arbiter

Arbitrates the single-port image BRAM between three requesters: the host loader/readback port, the SIMD fetch unit, and the SIMD write-back unit. It sits between the SIMD control FSM's fetch/write-back engines and the memory. It serialises their accesses, supports locked bursts so a fetch unit can read all neighbour pixels of a SIMD group back-to-back, and routes fixed-latency read data back to the issuing requester.

## Interface
- `AW`, 18: memory address width (512×512 pixels).
- `DW`, 8: pixel data width.
- `RD_LATENCY`, 1: BRAM cycles from registered command to valid `mem_rdata` (1..4).
- `LOCK_MAX`, 16: maximum consecutive grants to a locked owner.
- `MAX_WAIT`, 32: aging threshold in cycles (used only with `ARB_AGING_EN`).

Ports (requester index 0 = host, 1 = fetch, 2 = write-back):
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_i`  in  3  per-requester access request, level.
- `we_i`  in  3  per-requester write strobe, qualified by `req_i`.
- `lock_i`  in  3  per-requester burst lock, qualified by `req_i`.
- `addr_i`  in  3*AW  packed addresses; requester k occupies `[k*AW +: AW]`.
- `wdata_i`  in  3*DW  packed write data, same packing as `addr_i`.
- `gnt_o`  out  3  one-hot combinational grant; a request is accepted in any cycle where `req_i[k] & gnt_o[k]`.
- `rvalid_o`  out  3  one-hot read-data-valid for the requester that issued the read.
- `rdata_o`  out  DW  read data, shared by all requesters, qualified by `rvalid_o`.
- `mem_en`, `mem_we`  out  1  registered memory command.
- `mem_addr`  out  AW  registered memory address.
- `mem_wdata`  out  DW  registered memory write data.
- `mem_rdata`  in  DW  memory read data.
- `owner_o`  out  2  current lock owner; 3 = none.
- `busy_o`  out  1  high when a command is issued or a read is in flight.

## Operation
- States:
  - ST_IDLE: no owner.
  - ST_LOCKED: owner k holds the memory.
- ST_IDLE: grant the highest-priority pending request. Fixed priority is host > write-back > fetch.
  - If the granted request has `lock_i` high, go to ST_LOCKED, set owner = k and set `lock_cnt` = 1.
- ST_LOCKED: only owner k can be granted. `gnt_o[k]` = `req_i[k]`; all other grants stay 0.
  - `lock_cnt` increments on each grant to the owner.
- Return to ST_IDLE at the end of a cycle in which any of the following holds:
  - `req_i[k]` = 0;
  - `lock_i[k]` = 0 (that cycle's access is still granted and is the final beat);
  - `lock_cnt` = `LOCK_MAX` and a grant occurs. This forced release applies even if `lock_i` stays high.
- After a release, arbitration resumes in the next cycle. The previous owner does not re-lock in the release cycle.
- Read tracking: a granted read pushes a valid bit and a 2-bit requester ID into a shift pipeline of depth `1+RD_LATENCY`. A granted write pushes an invalid entry.
- `rvalid_o[id]` is asserted when the pipeline entry emerges. `rdata_o` = `mem_rdata` (pass-through).
- Writes return nothing to the requester.
- An empty cycle (no grant) holds `mem_en` = 0. The memory address and data registers keep their previous values.

## Timing
- Request accepted in cycle N (`gnt_o` is combinational in N).
- Command appears at `mem_*` in N+1.
- Read data and `rvalid_o` appear in N+1+`RD_LATENCY` (N+2 by default).
- Throughput is one access per cycle, with reads and writes freely interleaved. Back-to-back reads return in order.
- Simultaneous requests from all three requesters in ST_IDLE: host is granted; the others see `gnt_o` = 0 and must hold their request.
- A requester that drops `req_i` before being granted has its request discarded; there is no queuing.
- Reset, including mid-operation:
  - `gnt_o` = 0, `rvalid_o` = 0, `mem_en` = 0, `mem_we` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0, `rdata_o` passes `mem_rdata`.
  - `owner_o` = 3, `busy_o` = 0.
  - State returns to ST_IDLE and the read pipeline is cleared; in-flight reads never signal `rvalid_o`.
- `gnt_o` is forced to 0 while `rst` is high.

## Configuration
- `ARB_AGING_EN` defined: a per-requester `wait_cnt` increments each cycle that `req_i` is high without a grant, and clears on grant or when `req_i` drops.
  - A requester with `wait_cnt` ≥ `MAX_WAIT` is promoted above fixed priority in ST_IDLE. Among aged requesters, the lowest index wins.
  - Aging never breaks an active lock; it takes effect at the next release.
- `ARB_AGING_EN` undefined: pure fixed priority with no counters. Fetch can starve under continuous host or write-back traffic.

## Test plan
- Single fetch read at address 0x00123 with `RD_LATENCY` = 1:
  - `gnt_o` = 3'b010 in N, `mem_en` = 1 and `mem_addr` = 0x00123 in N+1, `rvalid_o` = 3'b010 with `rdata_o` = `mem_rdata` in N+2.
- All three requesters assert reads simultaneously, each holding until granted:
  - grants occur in the order host, write-back, fetch, in consecutive cycles;
  - each `rvalid_o` bit appears 2 cycles after its grant.
- Fetch locks a 4-read burst while write-back requests continuously:
  - fetch is granted 4 consecutive cycles and `owner_o` = 1;
  - write-back is granted on the first cycle after the cycle in which `lock_i[1]` drops.
- Fetch holds `lock_i` high for 20 cycles with `LOCK_MAX` = 16:
  - forced release after the 16th grant and `owner_o` returns to 3;
  - a pending host request is granted in the next cycle.
- Assert `rst` one cycle after a fetch read is granted:
  - no `rvalid_o` pulse is seen;
  - all outputs hold their reset values;
  - after reset deasserts, a new read returns normally.
- With `ARB_AGING_EN` and `MAX_WAIT` = 32, host and fetch both request continuously:
  - fetch is granted within 33 cycles of asserting `req_i`;
  - without the macro, fetch is never granted.

Source files
------------

// File: rtl/dsa_mem_arbiter.sv
// dsa_mem_arbiter: single-port image BRAM arbiter for host, fetch and write-back.
// Define ARB_AGING_EN to promote long-waiting requesters above fixed priority.
module dsa_mem_arbiter #(
  parameter int AW         = 18,
  parameter int DW         = 8,
  parameter int RD_LATENCY = 1,
  parameter int LOCK_MAX   = 16,
  parameter int MAX_WAIT   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req_i,
  input  logic [2:0]      we_i,
  input  logic [2:0]      lock_i,
  input  logic [3*AW-1:0] addr_i,
  input  logic [3*DW-1:0] wdata_i,
  output logic [2:0]      gnt_o,
  output logic [2:0]      rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [1:0]      owner_o,
  output logic            busy_o
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  if (RD_LATENCY < 1 || RD_LATENCY > 4 || LOCK_MAX < 1 || MAX_WAIT < 1)
  begin : g_bad_cfg
    $error("dsa_mem_arbiter: illegal parameter set");
  end

  state_t          state, state_nxt;
  logic [1:0]      owner, owner_nxt;
  logic [CW-1:0]   lock_cnt, lock_cnt_nxt;
  logic [2:0]      gnt;
  logic            any_gnt;
  logic [1:0]      gid;
  logic            sel_we;
  logic            sel_lock;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [RD_LATENCY:0] pv;
  logic [1:0]      pid [RD_LATENCY+1];

`ifdef ARB_AGING_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt [3];
  logic [2:0]    aged;

  // Per-requester wait counters, saturating at the aging threshold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) wait_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (req_i[k] && !gnt[k]) begin
          if (wait_cnt[k] < WW'(MAX_WAIT))
            wait_cnt[k] <= wait_cnt[k] + 1'b1;
        end else begin
          wait_cnt[k] <= '0;
        end
      end
    end
  end

  // Requesters that have waited long enough to jump the fixed order
  always_comb begin
    for (int k = 0; k < 3; k++)
      aged[k] = req_i[k] && (wait_cnt[k] >= WW'(MAX_WAIT));
  end
`endif

  // Lock state, owner and burst beat count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= 2'd3;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Enter a lock on a locked grant; leave on drop, unlock or the LOCK_MAX-th beat
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ST_IDLE: begin
        if (any_gnt && sel_lock && LOCK_MAX > 1) begin
          state_nxt    = ST_LOCKED;
          owner_nxt    = gid;
          lock_cnt_nxt = CW'(1);
        end
      end
      ST_LOCKED: begin
        if (!any_gnt || !sel_lock ||
            lock_cnt == CW'(LOCK_MAX - 1)) begin
          state_nxt    = ST_IDLE;
          owner_nxt    = 2'd3;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        owner_nxt    = 2'd3;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  // Grant: owner only while locked, else aged-first then host > wb > fetch
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (state == ST_LOCKED) begin
        case (owner)
          2'd0:    gnt[0] = req_i[0];
          2'd1:    gnt[1] = req_i[1];
          2'd2:    gnt[2] = req_i[2];
          default: gnt    = '0;
        endcase
      end else begin
`ifdef ARB_AGING_EN
        if (|aged) begin
          if (aged[0])      gnt = 3'b001;
          else if (aged[1]) gnt = 3'b010;
          else              gnt = 3'b100;
        end else
`endif
        if (req_i[0])      gnt = 3'b001;
        else if (req_i[2]) gnt = 3'b100;
        else if (req_i[1]) gnt = 3'b010;
      end
    end
  end

  // Route the granted requester's command fields
  always_comb begin
    any_gnt = |gnt;
    gid     = gnt[0] ? 2'd0 : (gnt[1] ? 2'd1 : 2'd2);
    case (gid)
      2'd0: begin
        sel_we    = we_i[0];
        sel_lock  = lock_i[0];
        sel_addr  = addr_i[0 +: AW];
        sel_wdata = wdata_i[0 +: DW];
      end
      2'd1: begin
        sel_we    = we_i[1];
        sel_lock  = lock_i[1];
        sel_addr  = addr_i[AW +: AW];
        sel_wdata = wdata_i[DW +: DW];
      end
      default: begin
        sel_we    = we_i[2];
        sel_lock  = lock_i[2];
        sel_addr  = addr_i[2*AW +: AW];
        sel_wdata = wdata_i[2*DW +: DW];
      end
    endcase
  end

  // Registered memory command; address/data hold on idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= any_gnt;
      mem_we <= any_gnt & sel_we;
      if (any_gnt) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
    end
  end

  // Read-return tracker aligned with the fixed BRAM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) pid[i] <= 2'd0;
    end else begin
      pv[0]  <= any_gnt & ~sel_we;
      pid[0] <= gid;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end

  // Steer read-valid to the requester that issued the emerging read
  always_comb begin
    rvalid_o = '0;
    if (pv[RD_LATENCY]) begin
      case (pid[RD_LATENCY])
        2'd0:    rvalid_o = 3'b001;
        2'd1:    rvalid_o = 3'b010;
        2'd2:    rvalid_o = 3'b100;
        default: rvalid_o = '0;
      endcase
    end
  end

  assign gnt_o   = gnt;
  assign rdata_o = mem_rdata;
  assign owner_o = owner;
  assign busy_o  = mem_en | (|pv);

endmodule
